// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the MM:SS:CC BCD countdown timer.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam logic [7:0] MAX_CC = 8'h99;
  localparam logic [7:0] MAX_SS = 8'h59;

  // A packed BCD pair is legal when its ones digit is a decimal digit and the
  // whole pair does not exceed the field's maximum (this bounds the tens digit).
  function automatic logic bcd_valid(input logic [7:0] value, input logic [7:0] max);
    return (value[3:0] <= 4'd9) && (value <= max);
  endfunction

endpackage

// File: rtl/bcd_down_pair.sv
// Two-digit packed BCD down counter with wrap to MAX and a borrow-out.
module bcd_down_pair #(
  parameter logic [7:0] MAX = 8'h99
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       ld,
  input  logic [7:0] ld_val,
  input  logic       dec,
  output logic [7:0] q,
  output logic       bo
);

  logic [7:0] q_q, q_d;

  // Next value: clear beats load beats decrement; ones digit borrows from tens.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 8'h00;
    end else if (ld) begin
      q_d = ld_val;
    end else if (dec) begin
      if (q_q == 8'h00) begin
        q_d = MAX;
      end else if (q_q[3:0] == 4'd0) begin
        q_d = {q_q[7:4] - 4'd1, 4'd9};
      end else begin
        q_d = {q_q[7:4], q_q[3:0] - 4'd1};
      end
    end
  end

  // Digit pair register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= 8'h00;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign bo = dec && (q_q == 8'h00);

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS:CC countdown timer: prescaled centisecond tick driving a BCD borrow chain.
//
//   state   | meaning
//   IDLE    | holding a loaded (or cleared) value, prescaler at 0
//   RUN     | prescaler advancing, one cc decrement per tick
//   PAUSE   | counting suspended, prescaler frozen mid-tick
//   EXPIRED | reached 00:00:00, done high until clear or valid load
module bcd_countdown_timer
  import bcd_timer_pkg::*;
#(
  parameter int TICK_DIV = 500000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic [7:0] load_cc,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic [7:0] cc,
  output logic       running,
  output logic       done,
  output logic       done_pulse,
  output logic       load_err
);

  localparam int              PS_W    = $clog2(TICK_DIV);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  state_e          state_q, state_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic            done_pulse_q, load_err_q;

  logic in_run, value_zero, load_ok, load_act, load_take, load_rej;
  logic tick, last_tick, start_ok;
  logic cc_bo, ss_bo, mm_bo_unused;

  // Strobe qualification; load is only honoured outside RUN and loses to clear.
  // Pause in RUN holds the prescaler, so a paused cycle is never a tick.
  always_comb begin
    in_run     = (state_q == ST_RUN);
    value_zero = (mm == 8'h00) && (ss == 8'h00) && (cc == 8'h00);
    load_ok    = bcd_valid(load_mm, MAX_SS) && bcd_valid(load_ss, MAX_SS)
                 && bcd_valid(load_cc, MAX_CC);
    load_act   = load && !clear && !in_run;
    load_take  = load_act && load_ok;
    load_rej   = load_act && !load_ok;
    tick       = in_run && !clear && !pause && (ps_q == PS_LAST);
    last_tick  = tick && (mm == 8'h00) && (ss == 8'h00) && (cc == 8'h01);
    start_ok   = start && !value_zero
                 && ((state_q == ST_IDLE) || (state_q == ST_PAUSE));
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state with priority clear > load > pause > start.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else if (load_act) begin
      if (load_ok) state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (pause)          state_d = ST_PAUSE;
          else if (last_tick) state_d = ST_EXPIRED;
        end
        ST_IDLE, ST_PAUSE: begin
          if (start_ok) state_d = ST_RUN;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // State-decoded level outputs.
  always_comb begin
    running = (state_q == ST_RUN);
    done    = (state_q == ST_EXPIRED);
  end

  // Prescaler: restarts on clear, valid load and a fresh start from IDLE;
  // a resume from PAUSE keeps the partial tick.
  always_comb begin
    ps_d = ps_q;
    if (clear || load_take) begin
      ps_d = '0;
    end else if ((state_q == ST_IDLE) && start_ok) begin
      ps_d = '0;
    end else if (in_run && !pause) begin
      ps_d = (ps_q == PS_LAST) ? '0 : ps_q + PS_W'(1);
    end
  end

  // Prescaler register and one-cycle event pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ps_q         <= '0;
      done_pulse_q <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      ps_q         <= ps_d;
      done_pulse_q <= (state_q != ST_EXPIRED) && (state_d == ST_EXPIRED);
      load_err_q   <= load_rej;
    end
  end

  assign done_pulse = done_pulse_q;
  assign load_err   = load_err_q;

  bcd_down_pair #(.MAX(MAX_CC)) u_cc (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (clear),
    .ld     (load_take),
    .ld_val (load_cc),
    .dec    (tick),
    .q      (cc),
    .bo     (cc_bo)
  );

  bcd_down_pair #(.MAX(MAX_SS)) u_ss (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (clear),
    .ld     (load_take),
    .ld_val (load_ss),
    .dec    (cc_bo),
    .q      (ss),
    .bo     (ss_bo)
  );

  // Minutes never borrow: expiry stops the chain before mm could wrap.
  bcd_down_pair #(.MAX(MAX_SS)) u_mm (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (clear),
    .ld     (load_take),
    .ld_val (load_mm),
    .dec    (ss_bo),
    .q      (mm),
    .bo     (mm_bo_unused)
  );

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: directed scenarios then random strobes,
// every cycle compared with a centisecond-arithmetic reference model.
module tb_bcd_countdown_timer;

  localparam int TD = 4;
  localparam int MI = 0, MR = 1, MP = 2, ME = 3;

  logic       clk;
  logic       reset_n;
  logic       load, start, pause, clear;
  logic [7:0] load_mm, load_ss, load_cc;
  logic [7:0] mm, ss, cc;
  logic       running, done, done_pulse, load_err;
  logic [27:0] dut_vec;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model: total centiseconds, mode, cycles into the current tick
  int m_val, m_mode, m_phase;
  bit m_pulse, m_err;

  bcd_countdown_timer #(.TICK_DIV(TD)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .load_mm   (load_mm),
    .load_ss   (load_ss),
    .load_cc   (load_cc),
    .start     (start),
    .pause     (pause),
    .clear     (clear),
    .mm        (mm),
    .ss        (ss),
    .cc        (cc),
    .running   (running),
    .done      (done),
    .done_pulse(done_pulse),
    .load_err  (load_err)
  );

  assign dut_vec = {mm, ss, cc, running, done, done_pulse, load_err};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic logic [27:0] model_vec();
    return {bcd(m_val / 6000), bcd((m_val / 100) % 60), bcd(m_val % 100),
            m_mode == MR, m_mode == ME, m_pulse, m_err};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_val = 0; m_mode = MI; m_phase = 0; m_pulse = 0; m_err = 0;
  endtask

  task automatic model_step(input bit c, input bit l, input bit p, input bit s,
                            input logic [7:0] lm, input logic [7:0] ls, input logic [7:0] lc);
    bit ok;
    m_pulse = 0;
    m_err   = 0;
    if (c) begin
      m_val = 0; m_mode = MI; m_phase = 0;
    end else if (l && m_mode != MR) begin
      ok = (lm[3:0] <= 9) && (lm[7:4] <= 5) && (ls[3:0] <= 9) && (ls[7:4] <= 5)
           && (lc[3:0] <= 9) && (lc[7:4] <= 9);
      if (ok) begin
        m_val = (int'(lm[7:4]) * 10 + int'(lm[3:0])) * 6000
              + (int'(ls[7:4]) * 10 + int'(ls[3:0])) * 100
              +  int'(lc[7:4]) * 10 + int'(lc[3:0]);
        m_mode = MI; m_phase = 0;
      end else begin
        m_err = 1;
      end
    end else if (m_mode == MR) begin
      if (p) begin
        m_mode = MP;
      end else if (m_phase == TD - 1) begin
        m_phase = 0;
        m_val--;
        if (m_val == 0) begin
          m_mode = ME; m_pulse = 1;
        end
      end else begin
        m_phase++;
      end
    end else if ((m_mode == MI || m_mode == MP) && s && m_val != 0) begin
      if (m_mode == MI) m_phase = 0;
      m_mode = MR;
    end
  endtask

  // one clock with the given strobes, then model update and full compare
  task automatic cyc(input bit c, input bit l, input bit p, input bit s,
                     input logic [7:0] lm, input logic [7:0] ls, input logic [7:0] lc);
    clear = c; load = l; pause = p; start = s;
    load_mm = lm; load_ss = ls; load_cc = lc;
    @(posedge clk); #1;
    model_step(c, l, p, s, lm, ls, lc);
    clear = 0; load = 0; pause = 0; start = 0;
    check("cycle", 32'(dut_vec), 32'(model_vec()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic do_load(input logic [7:0] lm, input logic [7:0] ls, input logic [7:0] lc);
    cyc(0, 1, 0, 0, lm, ls, lc);
  endtask

  task automatic do_start();
    cyc(0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic do_pause();
    cyc(0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic do_clear();
    cyc(1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
  endtask

  initial begin
    int pulses, at, r;
    bit c, l, p, s;
    logic [7:0] lm, ls, lc;

    reset_n = 1'b0;
    load = 0; start = 0; pause = 0; clear = 0;
    load_mm = 0; load_ss = 0; load_cc = 0;
    model_reset();
    #12;
    check("reset_state", 32'(dut_vec), 32'(0));
    reset_n = 1'b1;
    idle(2);

    // 1. basic expiry
    do_load(8'h00, 8'h00, 8'h05);
    check("t1_loaded", {8'h00, mm, ss, cc}, 32'h0000_0005);
    do_start();
    pulses = 0; at = 0;
    for (int i = 1; i <= 30; i++) begin
      idle(1);
      if (done_pulse) begin
        pulses++;
        at = i;
      end
    end
    check("t1_pulse_count", pulses, 1);
    check("t1_pulse_at", at, 20);
    check("t1_done_level", 32'(done), 1);
    check("t1_running", 32'(running), 0);
    check("t1_value", {8'h00, mm, ss, cc}, 32'h0);

    // 2. borrow chain
    do_load(8'h01, 8'h00, 8'h00);
    do_start();
    idle(TD);
    check("t2_borrow_mm", {8'h00, mm, ss, cc}, 32'h0000_5999);
    do_clear();
    do_load(8'h00, 8'h10, 8'h00);
    do_start();
    idle(TD);
    check("t2_borrow_ss", {8'h00, mm, ss, cc}, 32'h0000_0999);
    do_clear();

    // 3. invalid loads
    do_load(8'h00, 8'h00, 8'h07);
    do_load(8'h00, 8'h6A, 8'h00);
    check("t3_err_6A", 32'(load_err), 1);
    check("t3_hold_6A", {8'h00, mm, ss, cc}, 32'h0000_0007);
    idle(1);
    check("t3_err_one_cycle", 32'(load_err), 0);
    do_load(8'h00, 8'h60, 8'h00);
    check("t3_err_60", 32'(load_err), 1);
    check("t3_hold_60", {8'h00, mm, ss, cc}, 32'h0000_0007);
    do_load(8'h59, 8'h59, 8'h99);
    check("t3_max_ok", {7'h00, load_err, mm, ss, cc}, 32'h0059_5999);
    do_load(8'h00, 8'h00, 8'h07);

    // 4. pause / resume
    do_start();
    idle(2);
    do_pause();
    idle(10);
    check("t4_frozen", {8'h00, mm, ss, cc}, 32'h0000_0007);
    check("t4_paused_running", 32'(running), 0);
    do_start();
    idle(1);
    check("t4_resume_hold", {8'h00, mm, ss, cc}, 32'h0000_0007);
    idle(1);
    check("t4_resume_dec", {8'h00, mm, ss, cc}, 32'h0000_0006);
    cyc(0, 0, 1, 1, 8'h00, 8'h00, 8'h00);
    check("t4_pause_wins", 32'(running), 0);
    do_clear();

    // 5. zero start and clear during run
    do_start();
    check("t5_zero_start", 32'(running), 0);
    do_load(8'h00, 8'h30, 8'h00);
    do_start();
    idle(5);
    do_clear();
    check("t5_clear_value", {8'h00, mm, ss, cc}, 32'h0);
    check("t5_clear_flags", {running, done, done_pulse}, 32'h0);
    idle(3);

    // 6. asynchronous reset mid-run
    do_load(8'h00, 8'h00, 8'h09);
    do_start();
    idle(5);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("t6_async_reset", 32'(dut_vec), 32'(0));
    @(posedge clk); #1;
    check("t6_reset_held", 32'(dut_vec), 32'(0));
    #2;
    reset_n = 1'b1;
    idle(2);
    do_load(8'h00, 8'h00, 8'h09);
    do_start();
    idle(TD - 1);
    check("t6_no_early_tick", {8'h00, mm, ss, cc}, 32'h0000_0009);
    idle(1);
    check("t6_first_tick", {8'h00, mm, ss, cc}, 32'h0000_0008);
    do_clear();

    // random strobes against the model
    for (int k = 0; k < 600; k++) begin
      c = ($urandom_range(0, 39) == 0);
      l = ($urandom_range(0, 9) == 0);
      r = $urandom_range(0, 11);
      p = (r == 0);
      s = (r == 1 || r == 2);
      if ($urandom_range(0, 3) == 0) begin
        lm = 8'($urandom);
        ls = 8'($urandom);
        lc = 8'($urandom);
      end else begin
        lm = ($urandom_range(0, 7) == 0) ? bcd(1) : 8'h00;
        ls = bcd($urandom_range(0, 1));
        lc = bcd($urandom_range(0, 99));
      end
      cyc(c, l, p, s, lm, ls, lc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
